// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage sampled at OVERSAMPLE x the baud rate,
// with mid-bit start validation and separate good-byte / framing-error strobes.
module uart_receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] BIT_LAST  = SAMP_W'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_div;
    logic [SAMP_W-1:0] r_samp;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_ferr;
    logic              w_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Divider is held at zero in IDLE so tick phase is aligned to the start edge.
    assign w_tick = (r_state != S_IDLE) && (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_samp  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_samp  <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_samp == HALF_LAST) begin
                            r_samp  <= '0;
                            r_bit   <= '0;
                            r_state <= r_rx_s ? S_IDLE : S_DATA;
                        end else begin
                            r_samp <= r_samp + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_samp == BIT_LAST) begin
                            r_samp  <= '0;
                            r_shift <= {r_rx_s, r_shift[7:1]};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == 3'd7) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_samp <= r_samp + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_samp == BIT_LAST) begin
                            r_samp <= '0;
                            if (r_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_WAIT_HIGH;
                            end
                        end else begin
                            r_samp <= r_samp + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line must return high before a new start is accepted.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_samp  <= '0;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage: the downstream consumer of the byte stream our transmitter puts on its `tx` line. It samples an asynchronous 8N1 line (idle high, one start bit, 8 data bits LSB-first, one stop bit) at OVERSAMPLE× the baud rate and validates the start bit at mid-bit. It presents each received byte with a one-cycle valid strobe, and signals framing errors separately. It sits between the board-level RX pin and the command/decoder logic.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit. Even, ≥4.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE): clocks per sample tick (derived localparam). Must be ≥1.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  8  last correctly framed byte; holds until next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- Synchronizer: rx passes through 2 flops (reset value 1); all logic uses the second flop (`rx_s`).
- Tick generator: divider counter (width clog2(DIV)) held at 0 in IDLE and counts otherwise. `tick` is asserted in the cycle where counter == DIV-1, after which the counter wraps to 0. Clearing the counter in IDLE aligns tick phase to the start edge.
- Sample counter: clog2(OVERSAMPLE) bits, counts ticks, cleared on every state change. Bit counter: 3 bits.
- States:
  - IDLE: when rx_s == 0, go to START.
  - START: after OVERSAMPLE/2 ticks, sample rx_s. If 0, go to DATA (bit counter = 0). If 1, treat as a glitch: go to IDLE with no flags.
  - DATA: every OVERSAMPLE ticks, sample rx_s into the shift register. Shift right; the new bit enters bit 7, giving LSB-first assembly. After bit counter reaches 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: data_out ← shift register, pulse data_valid, go to IDLE.
    - If 0: pulse frame_err, leave data_out unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition or low line from being read as back-to-back frames.
- data_valid and frame_err are registered and never asserted together.
- Reset values: data_out = 0x00, data_valid = 0, frame_err = 0, busy = 0, state = IDLE, all counters 0, sync flops = 1.
- Reset asserted mid-frame aborts the frame with no flags. The next frame after reset release is received normally.

## Timing
- Input latency: rx to rx_s is 2 clocks.
- Frame timing from the first clock rx_s reads 0:
  - START sample occurs at tick (OVERSAMPLE/2).
  - Data bit n is sampled at tick OVERSAMPLE/2 + (n+1)·OVERSAMPLE.
  - Stop bit is sampled at tick OVERSAMPLE/2 + 9·OVERSAMPLE.
  - Each tick is DIV clocks.
- data_valid / frame_err rise in the clock after the stop-sample tick and last exactly 1 clock.
- busy drops in the same cycle data_valid rises (on a good frame). After a framing error, busy stays high until WAIT_HIGH exits.
- Back-to-back frames: a start edge that arrives ≥½ bit after the stop-bit sample is accepted. No idle time beyond the stop bit is required.
- Bit-centre sampling tolerates ±(OVERSAMPLE/2 − 1)/OVERSAMPLE bit of cumulative skew, about ±4.5% at 16×.

## Test plan
All directed tests use CLK_FREQ=32_000_000, BAUD=1_000_000, OVERSAMPLE=16, giving DIV=2 and 32 clocks/bit.
- Single frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) → data_out=0xA5. data_valid high for 1 clock, 2+304+1 clocks after rx falls (±1). frame_err stays 0. busy high throughout.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop bit → two data_valid pulses, 320 clocks apart, carrying 0x00 then 0xFF. No frame_err.
- Glitch: rx low for 10 clocks, then high → no data_valid, no frame_err. busy returns to 0 within 20 clocks. A following 0x3C frame is received correctly.
- Framing error: frame 0x55 with stop bit held 0, then rx held low 200 clocks, then high → frame_err pulses once. data_out keeps its prior value (0x3C). No data_valid while rx stays low. After rx goes high, a 0x81 frame is received correctly.
- Reset mid-frame: rst_n low for 1 clock during data bit 3 of 0xF0 → all outputs 0 next clock, state IDLE. A subsequent full 0x5A frame yields data_out=0x5A with a single data_valid.
- Reset defaults: hold rst_n low 5 clocks with rx toggling → data_out=0, data_valid=0, frame_err=0, busy=0 throughout.
